// File: rtl/fpf_decoder_23_pkg.sv
// Shared FNS header for the 23-wire FPF encoder/decoder pair.
// Holds the decoded value width (FBLEN23), the Fibonacci weights FNS01..FNS25,
// the partial-sum group boundaries (8/8/7 bits) and helpers that compute
// weighted group sums.
package fpf_decoder_23_pkg;

  localparam int unsigned FBLEN23 = 17;
  localparam int unsigned CODE_W  = 23;

  localparam int unsigned FNS01 = 1;
  localparam int unsigned FNS02 = 1;
  localparam int unsigned FNS03 = 2;
  localparam int unsigned FNS04 = 3;
  localparam int unsigned FNS05 = 5;
  localparam int unsigned FNS06 = 8;
  localparam int unsigned FNS07 = 13;
  localparam int unsigned FNS08 = 21;
  localparam int unsigned FNS09 = 34;
  localparam int unsigned FNS10 = 55;
  localparam int unsigned FNS11 = 89;
  localparam int unsigned FNS12 = 144;
  localparam int unsigned FNS13 = 233;
  localparam int unsigned FNS14 = 377;
  localparam int unsigned FNS15 = 610;
  localparam int unsigned FNS16 = 987;
  localparam int unsigned FNS17 = 1597;
  localparam int unsigned FNS18 = 2584;
  localparam int unsigned FNS19 = 4181;
  localparam int unsigned FNS20 = 6765;
  localparam int unsigned FNS21 = 10946;
  localparam int unsigned FNS22 = 17711;
  localparam int unsigned FNS23 = 28657;
  localparam int unsigned FNS24 = 46368;
  localparam int unsigned FNS25 = 75025;

  // Partial-sum groups: [7:0], [15:8], [22:16]
  localparam int unsigned GRP0_LO = 0;
  localparam int unsigned GRP0_HI = 7;
  localparam int unsigned GRP1_LO = 8;
  localparam int unsigned GRP1_HI = 15;
  localparam int unsigned GRP2_LO = 16;
  localparam int unsigned GRP2_HI = 22;

  typedef logic [FBLEN23-1:0] fns_val_t;

  typedef struct packed {
    fns_val_t p0;
    fns_val_t p1;
    fns_val_t p2;
  } psum_t;

  // Weight of codeword bit k is FNS(k+1).
  function automatic fns_val_t fns_weight(input int unsigned k);
    int unsigned w;
    case (k)
      0:       w = FNS01;
      1:       w = FNS02;
      2:       w = FNS03;
      3:       w = FNS04;
      4:       w = FNS05;
      5:       w = FNS06;
      6:       w = FNS07;
      7:       w = FNS08;
      8:       w = FNS09;
      9:       w = FNS10;
      10:      w = FNS11;
      11:      w = FNS12;
      12:      w = FNS13;
      13:      w = FNS14;
      14:      w = FNS15;
      15:      w = FNS16;
      16:      w = FNS17;
      17:      w = FNS18;
      18:      w = FNS19;
      19:      w = FNS20;
      20:      w = FNS21;
      21:      w = FNS22;
      22:      w = FNS23;
      23:      w = FNS24;
      24:      w = FNS25;
      default: w = 0;
    endcase
    return fns_val_t'(w);
  endfunction

  function automatic fns_val_t group_sum(input logic [CODE_W-1:0] code,
                                         input int unsigned lo,
                                         input int unsigned hi);
    fns_val_t s;
    s = '0;
    for (int unsigned k = lo; k <= hi; k++) begin
      if (code[k]) s = s + fns_weight(k);
    end
    return s;
  endfunction

endpackage

// File: rtl/fpf_decoder_23_pattern_check.sv
// fpf_pattern_check: combinational forbidden-pattern detector.
// Flags any interior triplet (bits i+1,i,i-1 for i = 1..21) equal to 010 or
// 101. Bits 0 and 22 are never checked as centres.
// Ports:
//   i_code  in  23  codeword
//   o_err   out 1   forbidden pattern present
module fpf_pattern_check
  import fpf_decoder_23_pkg::*;
(
  input  logic [CODE_W-1:0] i_code,
  output logic              o_err
);

  always_comb begin
    o_err = 1'b0;
    for (int unsigned i = 1; i <= CODE_W - 2; i++) begin
      if (i_code[i+1 -: 3] == 3'b010 || i_code[i+1 -: 3] == 3'b101) o_err = 1'b1;
    end
  end

endmodule

// File: rtl/fpf_decoder_23.sv
// fpf_decoder_23: two-stage pipelined decoder from 23-wire FPF codewords to
// their FNS binary value (sum of code_in[k] * FNS(k+1)).
// S1 registers three group partial sums, S2 registers their total.
// Optional build macro: FPF_CHECK_EN -- instantiates fpf_pattern_check and
// carries its flag through both stages on code_err; otherwise code_err = 0.
// Ports:
//   clock      in  1   rising-edge clock
//   reset      in  1   asynchronous active-high reset
//   code_in    in  23  received codeword
//   in_valid   in  1   code_in valid
//   in_ready   out 1   decoder can accept a word
//   data_out   out 17  decoded value
//   out_valid  out 1   data_out/code_err valid
//   out_ready  in  1   downstream accepts output
//   code_err   out 1   forbidden pattern seen (FPF_CHECK_EN only)
module fpf_decoder_23
  import fpf_decoder_23_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic [CODE_W-1:0]  code_in,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [FBLEN23-1:0] data_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               code_err
);

  logic         w_s2_adv;
  logic         w_s1_adv;
  psum_t        w_psum;
  psum_t        r_psum;
  logic         r_s1_valid;
  logic         r_out_valid;
  fns_val_t     r_data;

  // Backpressure ripples combinationally from out_ready to in_ready.
  assign w_s2_adv = !r_out_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;

  always_comb begin
    w_psum.p0 = group_sum(code_in, GRP0_LO, GRP0_HI);
    w_psum.p1 = group_sum(code_in, GRP1_LO, GRP1_HI);
    w_psum.p2 = group_sum(code_in, GRP2_LO, GRP2_HI);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s1_valid  <= 1'b0;
      r_psum      <= '0;
      r_out_valid <= 1'b0;
      r_data      <= '0;
    end else begin
      if (w_s1_adv) begin
        r_s1_valid <= in_valid;
        if (in_valid) r_psum <= w_psum;
      end
      if (w_s2_adv) begin
        r_out_valid <= r_s1_valid;
        // Max total is 75024 < 2^17, so no overflow handling is needed.
        if (r_s1_valid) r_data <= r_psum.p0 + r_psum.p1 + r_psum.p2;
      end
    end
  end

  assign in_ready  = w_s1_adv;
  assign out_valid = r_out_valid;
  assign data_out  = r_data;

`ifdef FPF_CHECK_EN
  logic w_chk_err;
  logic r_s1_err;
  logic r_out_err;

  fpf_pattern_check u_check (
    .i_code (code_in),
    .o_err  (w_chk_err)
  );

  // Error flag follows the same enables as the data so it stays aligned.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s1_err  <= 1'b0;
      r_out_err <= 1'b0;
    end else begin
      if (w_s1_adv && in_valid) r_s1_err  <= w_chk_err;
      if (w_s2_adv && r_s1_valid) r_out_err <= r_s1_err;
    end
  end

  assign code_err = r_out_err;
`else
  assign code_err = 1'b0;
`endif

endmodule

// File: tb/tb_fpf_decoder_23.sv
module tb_fpf_decoder_23;

`ifdef FPF_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  localparam int NV = 13;

  logic        clock = 1'b0;
  logic        reset;
  logic [22:0] code_in;
  logic        in_valid;
  logic        in_ready;
  logic [16:0] data_out;
  logic        out_valid;
  logic        out_ready;
  logic        code_err;

  fpf_decoder_23 dut (
    .clock     (clock),
    .reset     (reset),
    .code_in   (code_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_out  (data_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .code_err  (code_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [22:0] code;
    logic [16:0] data;
    bit          err;
  } vec_t;

  typedef struct {
    logic [16:0] data;
    logic        err;
    int unsigned cyc;
    bit          lat;
  } exp_t;

  vec_t        vecs[NV];
  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int          n_acc = 0;
  bit          rand_rdy = 1'b0;

  always @(posedge clock) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Present vector idx from the next falling edge until accepted.
  task automatic send(input int idx, input bit lat);
    bit   done;
    exp_t e;
    done = 1'b0;
    @(negedge clock);
    code_in  = vecs[idx].code;
    in_valid = 1'b1;
    for (int t = 0; t < 200 && !done; t++) begin
      #1;
      if (in_ready) begin
        e.data = vecs[idx].data;
        e.err  = CHK && vecs[idx].err;
        e.cyc  = cyc;
        e.lat  = lat;
        sb.push_back(e);
        n_acc++;
        done = 1'b1;
      end else begin
        @(negedge clock);
      end
    end
    if (!done) chk("send_timeout", 32'd1, 32'd0);
  endtask

  task automatic idle();
    @(negedge clock);
    in_valid = 1'b0;
    code_in  = 23'($urandom);
  endtask

  task automatic drain(input int budget);
    for (int t = 0; t < budget && (sb.size() != 0 || out_valid); t++) @(negedge clock);
    chk("drain_empty", sb.size(), 0);
  endtask

  always @(negedge clock) begin
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: output must match the scoreboard head whenever it is presented.
  always @(negedge clock) begin
    #2;
    if (!reset && out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", 32'd1, 32'd0);
      end else begin
        chk("data_out", 32'(data_out), 32'(sb[0].data));
        chk("code_err", 32'(code_err), 32'(sb[0].err));
        if (out_ready) begin
          if (sb[0].lat) chk("latency_cycle", cyc, sb[0].cyc + 2);
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int base;
    vecs[0]  = '{23'h000000, 17'd0,     1'b0};
    vecs[1]  = '{23'h000001, 17'd1,     1'b0};
    vecs[2]  = '{23'h000003, 17'd2,     1'b0};
    vecs[3]  = '{23'h000007, 17'd4,     1'b0};
    vecs[4]  = '{23'h7FFFFF, 17'd75024, 1'b0};
    vecs[5]  = '{23'h000002, 17'd1,     1'b1};
    vecs[6]  = '{23'h400000, 17'd28657, 1'b0};
    vecs[7]  = '{23'h000005, 17'd3,     1'b1};
    vecs[8]  = '{23'h0000FF, 17'd54,    1'b0};
    vecs[9]  = '{23'h7F0000, 17'd72441, 1'b0};
    vecs[10] = '{23'h00FF00, 17'd2529,  1'b0};
    vecs[11] = '{23'h155555, 17'd17711, 1'b1};
    vecs[12] = '{23'h000006, 17'd3,     1'b0};

    reset     = 1'b1;
    in_valid  = 1'b0;
    code_in   = '0;
    out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clock);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_data_out", 32'(data_out), 0);
    chk("rst_code_err", 32'(code_err), 0);
    chk("rst_in_ready", 32'(in_ready), 1);

    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 1);
    @(negedge clock);
    #1;
    chk("empty_stall_in_ready", 32'(in_ready), 1);

    // Known codewords, streaming with out_ready high
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) send(i, 1'b1);
    idle();
    drain(50);

    // Backpressure: only two words fit, the third is held
    @(negedge clock);
    out_ready = 1'b0;
    base = n_acc;
    fork
      begin
        send(5, 1'b0);
        send(1, 1'b0);
        send(11, 1'b0);
        idle();
      end
    join_none
    repeat (6) @(negedge clock);
    #1;
    chk("bp_accepts", 32'(n_acc - base), 2);
    chk("bp_in_ready", 32'(in_ready), 0);
    chk("bp_out_valid", 32'(out_valid), 1);
    @(negedge clock);
    out_ready = 1'b1;
    for (int t = 0; t < 50 && n_acc < base + 3; t++) @(negedge clock);
    chk("bp_third_accept", 32'(n_acc - base), 3);
    repeat (2) @(negedge clock);
    drain(50);

    // Reset with two words in flight discards both
    @(negedge clock);
    out_ready = 1'b0;
    send(3, 1'b0);
    send(4, 1'b0);
    @(negedge clock);
    in_valid = 1'b0;
    reset    = 1'b1;
    sb.delete();
    #1;
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_data_out", 32'(data_out), 0);
    @(negedge clock);
    reset     = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(negedge clock);
    #1;
    chk("midrst_no_output", 32'(out_valid), 0);

    // Directed words under random handshake timing
    rand_rdy = 1'b1;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) idle();
      send(int'($urandom_range(0, NV - 1)), 1'b0);
    end
    idle();
    @(negedge clock);
    rand_rdy  = 1'b0;
    out_ready = 1'b1;
    drain(100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
